// File: rtl/alu_ctrl_seq_if.sv
// rtl/alu_ctrl_seq_if.sv - decode/handshake bundle between the EX-stage control and alu_ctrl_seq
//
// Purpose : groups the decode inputs, the flow-control inputs and the registered
//           control outputs of alu_ctrl_seq into a single port.
// Signals : valid_i, ALUOp_i[2:0], funct_i[5:0], stall_i, flush_i   (master -> slave)
//           ALUCtrl_o[CTRL_W-1:0], valid_o, busy_o, mc_start_o, illegal_o (slave -> master)
// Modports: master (pipeline / bench side), slave (alu_ctrl_seq side)

interface alu_ctrl_seq_if #(
    parameter int CTRL_W = 4
);
    logic              valid_i;
    logic [2:0]        ALUOp_i;
    logic [5:0]        funct_i;
    logic              stall_i;
    logic              flush_i;
    logic [CTRL_W-1:0] ALUCtrl_o;
    logic              valid_o;
    logic              busy_o;
    logic              mc_start_o;
    logic              illegal_o;

    modport master (
        output valid_i, ALUOp_i, funct_i, stall_i, flush_i,
        input  ALUCtrl_o, valid_o, busy_o, mc_start_o, illegal_o
    );

    modport slave (
        input  valid_i, ALUOp_i, funct_i, stall_i, flush_i,
        output ALUCtrl_o, valid_o, busy_o, mc_start_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered ALU control decoder with multi-cycle MUL/DIV sequencing
//
// Purpose : decodes ALUOp/funct into a 4-bit ALU op code, registers it, and
//           sequences multi-cycle ops (MUL, optionally DIV) with busy/start/valid.
// Ports   : clk_i  - clock, rising edge
//           rst_i  - asynchronous active-low reset
//           bus    - alu_ctrl_seq_if.slave (decode inputs, stall/flush, control outputs)
// Params  : CTRL_W (4), MUL_LAT (1..15), DIV_LAT (1..15), CNT_W (holds max latency-1)
// Config  : define ALU_CTRL_DIV_EN to decode funct 26 as a multi-cycle DIV (code 1001);
//           without it funct 26 is reported illegal.

module alu_ctrl_seq #(
    parameter int CTRL_W  = 4,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    alu_ctrl_seq_if.slave  bus
);

    localparam logic [CTRL_W-1:0] C_ADD  = CTRL_W'(4'b0000);
    localparam logic [CTRL_W-1:0] C_SUB  = CTRL_W'(4'b0010);
    localparam logic [CTRL_W-1:0] C_AND  = CTRL_W'(4'b0100);
    localparam logic [CTRL_W-1:0] C_OR   = CTRL_W'(4'b0101);
    localparam logic [CTRL_W-1:0] C_SLT  = CTRL_W'(4'b1010);
    localparam logic [CTRL_W-1:0] C_SLTU = CTRL_W'(4'b1011);
    localparam logic [CTRL_W-1:0] C_SLL  = CTRL_W'(4'b1101);
    localparam logic [CTRL_W-1:0] C_SLLV = CTRL_W'(4'b1100);
    localparam logic [CTRL_W-1:0] C_MUL  = CTRL_W'(4'b1000);
    localparam logic [CTRL_W-1:0] C_DIV  = CTRL_W'(4'b1001);
    localparam logic [CTRL_W-1:0] C_LUI  = CTRL_W'(4'b1111);

    // A latency of 1 means the op completes like any single-cycle op.
    localparam bit               MUL_MC  = (MUL_LAT > 1);
    localparam bit               DIV_MC  = (DIV_LAT > 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

`ifdef ALU_CTRL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MULTI = 1'b1
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CTRL_W-1:0] r_ctrl;
    logic              r_valid;
    logic              r_busy;
    logic              r_mc_start;
    logic              r_illegal;

    logic [CTRL_W-1:0] w_code;
    logic              w_illegal;
    logic              w_multi;
    logic [CNT_W-1:0]  w_lat;
    logic              w_accept;
    logic              w_hold;
    logic              w_last;

    always_comb begin
        w_code    = C_ADD;
        w_illegal = 1'b0;
        w_multi   = 1'b0;
        w_lat     = '0;
        case (bus.ALUOp_i)
            3'b100: begin
                case (bus.funct_i)
                    6'd32: w_code = C_ADD;
                    6'd34: w_code = C_SUB;
                    6'd36: w_code = C_AND;
                    6'd37: w_code = C_OR;
                    6'd42: w_code = C_SLT;
                    6'd43: w_code = C_SLTU;
                    6'd0:  w_code = C_SLL;
                    6'd4:  w_code = C_SLLV;
                    6'd24: begin
                        w_code  = C_MUL;
                        w_multi = MUL_MC;
                        w_lat   = MUL_CNT;
                    end
                    6'd26: begin
                        if (DIV_EN) begin
                            w_code  = C_DIV;
                            w_multi = DIV_MC;
                            w_lat   = DIV_CNT;
                        end else begin
                            w_illegal = 1'b1;
                        end
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            3'b000:  w_code = C_ADD;
            3'b101:  w_code = C_OR;
            3'b111:  w_code = C_LUI;
            3'b010:  w_code = C_SUB;
            default: w_illegal = 1'b1;
        endcase
    end

    // A stalled valid result must not be overwritten, so it also blocks acceptance.
    assign w_hold   = r_valid & bus.stall_i;
    assign w_accept = bus.valid_i & ~r_busy & ~w_hold & ~bus.flush_i;
    // Counter loads latency-1; the op is final on the edge that sees it at 1.
    assign w_last   = (r_cnt <= CNT_W'(1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_ctrl     <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_mc_start <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (bus.flush_i) begin
            // ALUCtrl_o deliberately keeps its last value across a flush.
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_mc_start <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_mc_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ctrl    <= w_code;
                        r_illegal <= w_illegal;
                        if (w_multi) begin
                            r_state    <= S_MULTI;
                            r_cnt      <= w_lat;
                            r_busy     <= 1'b1;
                            r_mc_start <= 1'b1;
                            r_valid    <= 1'b0;
                        end else begin
                            r_valid <= 1'b1;
                        end
                    end else if (!w_hold) begin
                        r_valid   <= 1'b0;
                        r_illegal <= 1'b0;
                    end
                end
                S_MULTI: begin
                    // Counting ignores stall; a stall only freezes the finished result.
                    if (w_last) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ALUCtrl_o  = r_ctrl;
    assign bus.valid_o    = r_valid;
    assign bus.busy_o     = r_busy;
    assign bus.mc_start_o = r_mc_start;
    assign bus.illegal_o  = r_illegal;

endmodule
